// File: rtl/pid_setpoint_scheduler_if.sv
// Signal bundle between the setpoint scheduler, the incremental PID unit and the loop controls.
// master = scheduler side, slave = PID/loop environment side.
interface pid_setpoint_scheduler_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  loop_enable_in;
    logic [DATA_WIDTH-1:0] target_value_in;
    logic [DATA_WIDTH-1:0] ramp_step_in;
    logic [DATA_WIDTH-1:0] detect_value_in;
    logic [DATA_WIDTH-1:0] set_value_out;
    logic [DATA_WIDTH-1:0] detect_value_out;
    logic                  pid_cal_enable_out;
    logic                  pid_cal_done_in;
    logic [DATA_WIDTH-1:0] pid_cal_value_in;
    logic [DATA_WIDTH-1:0] control_value_out;
    logic                  control_valid_out;
    logic                  tick_missed_out;
    logic                  pid_timeout_out;

    modport master (
        input  loop_enable_in, target_value_in, ramp_step_in, detect_value_in,
        input  pid_cal_done_in, pid_cal_value_in,
        output set_value_out, detect_value_out, pid_cal_enable_out,
        output control_value_out, control_valid_out, tick_missed_out, pid_timeout_out
    );

    modport slave (
        output loop_enable_in, target_value_in, ramp_step_in, detect_value_in,
        output pid_cal_done_in, pid_cal_value_in,
        input  set_value_out, detect_value_out, pid_cal_enable_out,
        input  control_value_out, control_valid_out, tick_missed_out, pid_timeout_out
    );
endinterface

// File: rtl/pid_setpoint_scheduler.sv
// Control-tick sequencer: slews the setpoint, launches one PID calculation per tick, republishes the result.
// Optional macro PID_DONE_TIMEOUT_EN adds a WAIT_DONE timeout (pid_timeout_out); otherwise it waits forever.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | loop off; setpoint tracks feedback for a bumpless start
// WAIT_TICK | loop on, waiting for the next control tick
// RAMP      | one clock: move setpoint toward target by at most one step
// LAUNCH    | one clock: PID enable pulse, feedback latched
// WAIT_DONE | waiting for the PID done strobe
module pid_setpoint_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int PERIOD_CNT  = 20000,
    parameter int TIMEOUT_CYC = 64
) (
    input logic                      sys_clk,
    input logic                      reset_n,
    pid_setpoint_scheduler_if.master bus
);
    localparam int CNT_W = (PERIOD_CNT > 2) ? $clog2(PERIOD_CNT) : 1;

    if (PERIOD_CNT < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("pid_setpoint_scheduler: PERIOD_CNT must be >= 2 and TIMEOUT_CYC >= 1");
    end

    typedef enum logic [4:0] {
        IDLE      = 5'b00001,
        WAIT_TICK = 5'b00010,
        RAMP      = 5'b00100,
        LAUNCH    = 5'b01000,
        WAIT_DONE = 5'b10000
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      tick_cnt;
    logic                  tick;
    logic [DATA_WIDTH-1:0] set_q;
    logic [DATA_WIDTH-1:0] detect_q;
    logic [DATA_WIDTH-1:0] ctrl_q;
    logic                  launch_q;
    logic                  valid_q;
    logic                  miss_q;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH:0]   diff_mag;
    logic [DATA_WIDTH-1:0] ramp_next;

    assign tick = (tick_cnt == CNT_W'(PERIOD_CNT - 1));

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
        end else if (!bus.loop_enable_in || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    // 17-bit difference cannot overflow; stepping toward target never overshoots it.
    assign diff      = {bus.target_value_in[DATA_WIDTH-1], bus.target_value_in}
                     - {set_q[DATA_WIDTH-1], set_q};
    assign diff_mag  = diff[DATA_WIDTH] ? (~diff + 1'b1) : diff;
    assign ramp_next = (diff_mag <= {1'b0, bus.ramp_step_in}) ? bus.target_value_in :
                       diff[DATA_WIDTH] ? (set_q - bus.ramp_step_in) : (set_q + bus.ramp_step_in);

`ifdef PID_DONE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;
    assign bus.pid_timeout_out = timeout_q;
`else
    assign bus.pid_timeout_out = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            set_q    <= '0;
            detect_q <= '0;
            ctrl_q   <= '0;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
            miss_q   <= 1'b0;
`ifdef PID_DONE_TIMEOUT_EN
            to_cnt    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
            miss_q   <= tick && (state != WAIT_TICK);
`ifdef PID_DONE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    set_q <= bus.detect_value_in;
                    if (bus.loop_enable_in) state <= WAIT_TICK;
                end
                WAIT_TICK: begin
                    if (!bus.loop_enable_in) state <= IDLE;
                    else if (tick)           state <= RAMP;
                end
                RAMP: begin
                    set_q <= ramp_next;
                    if (!bus.loop_enable_in) begin
                        state <= IDLE;
                    end else begin
                        state    <= LAUNCH;
                        launch_q <= 1'b1;
                        detect_q <= bus.detect_value_in;
`ifdef PID_DONE_TIMEOUT_EN
                        to_cnt <= TO_W'(TIMEOUT_CYC - 1);
`endif
                    end
                end
                LAUNCH: state <= WAIT_DONE;
                WAIT_DONE: begin
                    // A falling enable never aborts an outstanding calculation.
                    if (bus.pid_cal_done_in) begin
                        ctrl_q  <= bus.pid_cal_value_in;
                        valid_q <= 1'b1;
                        state   <= bus.loop_enable_in ? WAIT_TICK : IDLE;
                    end
`ifdef PID_DONE_TIMEOUT_EN
                    else if (to_cnt == '0) begin
                        timeout_q <= 1'b1;
                        state     <= WAIT_TICK;
                    end else begin
                        to_cnt <= to_cnt - 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.set_value_out      = set_q;
    assign bus.detect_value_out   = detect_q;
    assign bus.pid_cal_enable_out = launch_q;
    assign bus.control_value_out  = ctrl_q;
    assign bus.control_valid_out  = valid_q;
    assign bus.tick_missed_out    = miss_q;
endmodule

// File: tb/tb_pid_setpoint_scheduler.sv
// Scoreboard bench for pid_setpoint_scheduler: stimulus queues expected events, a monitor pops and compares.
// The timeout scenario is exercised only when PID_DONE_TIMEOUT_EN is defined.
module tb_pid_setpoint_scheduler;
    localparam int P  = 16;
    localparam int TO = 64;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    pid_setpoint_scheduler_if #(.DATA_WIDTH(16)) bus ();

    pid_setpoint_scheduler #(
        .DATA_WIDTH (16),
        .PERIOD_CNT (P),
        .TIMEOUT_CYC(TO)
    ) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    typedef enum int {EV_LAUNCH, EV_VALID, EV_MISS, EV_TMO} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [15:0] a;
        logic [15:0] b;
    } ev_t;

    ev_t         exp_q[$];
    int          launch_cyc[$];
    int          tmo_cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        done_at_edge = 1'b0;
    logic [15:0] pid_val = 16'h1234;
    int          pid_delay = 9;
    bit          pid_respond = 1'b1;

    always @(posedge sys_clk) begin
        cyc          <= cyc + 1;
        done_at_edge <= bus.pid_cal_done_in;
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [15:0] a, input logic [15:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input ev_kind_t k, input logic [15:0] a, input logic [15:0] b, input string name);
        ev_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL %s: unexpected event (a=%h b=%h), none queued", name, a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k) begin
                n_err++;
                $display("FAIL %s: got event kind %0d, expected kind %0d", name, k, e.kind);
            end else if (e.a !== a || e.b !== b) begin
                n_err++;
                $display("FAIL %s: got %h/%h, expected %h/%h", name, a, b, e.a, e.b);
            end
        end
    endtask

    // Monitor: samples DUT outputs on the falling edge.
    initial begin
        logic en_prev    = 1'b0;
        logic valid_prev = 1'b0;
        forever begin
            @(negedge sys_clk);
            if (reset_n) begin
                if (bus.tick_missed_out) pop_check(EV_MISS, 16'h0, 16'h0, "tick_missed");
                if (bus.pid_timeout_out) begin
                    tmo_cyc = cyc;
                    pop_check(EV_TMO, 16'h0, 16'h0, "pid_timeout");
                end
                if (bus.control_valid_out) begin
                    check16("valid_one_clk_after_done", {15'h0, done_at_edge}, 16'h1);
                    check16("valid_width", {15'h0, valid_prev}, 16'h0);
                    pop_check(EV_VALID, bus.control_value_out, 16'h0, "control_value");
                end
                if (bus.pid_cal_enable_out) begin
                    check16("enable_width", {15'h0, en_prev}, 16'h0);
                    launch_cyc.push_back(cyc);
                    pop_check(EV_LAUNCH, bus.set_value_out, bus.detect_value_out, "launch_set_detect");
                end
            end
            en_prev    = bus.pid_cal_enable_out;
            valid_prev = bus.control_valid_out;
        end
    end

    // PID model: done strobe pid_delay clocks after each enable pulse.
    initial begin
        bus.pid_cal_done_in  = 1'b0;
        bus.pid_cal_value_in = 16'h0;
        forever begin
            @(negedge sys_clk);
            if (bus.pid_cal_enable_out && pid_respond && reset_n) begin
                repeat (pid_delay) @(negedge sys_clk);
                bus.pid_cal_value_in = pid_val;
                bus.pid_cal_done_in  = 1'b1;
                @(negedge sys_clk);
                bus.pid_cal_done_in  = 1'b0;
            end
        end
    end

    task automatic wait_drain(input string name);
        for (int i = 0; i < 600; i++) begin
            @(negedge sys_clk);
            #1;
            if (exp_q.size() == 0) return;
        end
        n_vec++;
        n_err++;
        $display("FAIL %s: %0d expected events still pending after bound", name, exp_q.size());
        exp_q.delete();
    endtask

    task automatic start_phase(input string name, input logic [15:0] det, input logic [15:0] tgt,
                               input logic [15:0] stp);
        bus.loop_enable_in  = 1'b0;
        bus.detect_value_in = det;
        bus.target_value_in = tgt;
        bus.ramp_step_in    = stp;
        repeat (3) @(negedge sys_clk);
        check16({name, "_bumpless_set"}, bus.set_value_out, det);
        launch_cyc.delete();
        bus.loop_enable_in = 1'b1;
    endtask

    task automatic check_reset_outputs(input string name);
        check16({name, "_set"},     bus.set_value_out,     16'h0);
        check16({name, "_detect"},  bus.detect_value_out,  16'h0);
        check16({name, "_ctrl"},    bus.control_value_out, 16'h0);
        check16({name, "_enable"},  {15'h0, bus.pid_cal_enable_out}, 16'h0);
        check16({name, "_valid"},   {15'h0, bus.control_valid_out},  16'h0);
        check16({name, "_missed"},  {15'h0, bus.tick_missed_out},    16'h0);
        check16({name, "_timeout"}, {15'h0, bus.pid_timeout_out},    16'h0);
    endtask

    initial begin
        bus.loop_enable_in  = 1'b0;
        bus.target_value_in = 16'h0;
        bus.ramp_step_in    = 16'h0;
        bus.detect_value_in = 16'h0;
        reset_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // Ramp up from 0 toward 4000 in 1000 steps, then hold.
        pid_val = 16'h1234;
        pid_delay = 9;
        start_phase("ramp_up", 16'h0000, 16'h4000, 16'h1000);
        push_ev(EV_LAUNCH, 16'h1000, 16'h0); push_ev(EV_VALID, 16'h1234, 16'h0);
        push_ev(EV_LAUNCH, 16'h2000, 16'h0); push_ev(EV_VALID, 16'h1234, 16'h0);
        push_ev(EV_LAUNCH, 16'h3000, 16'h0); push_ev(EV_VALID, 16'h1234, 16'h0);
        push_ev(EV_LAUNCH, 16'h4000, 16'h0); push_ev(EV_VALID, 16'h1234, 16'h0);
        push_ev(EV_LAUNCH, 16'h4000, 16'h0); push_ev(EV_VALID, 16'h1234, 16'h0);
        wait_drain("ramp_up");
        bus.loop_enable_in = 1'b0;
        if (launch_cyc.size() >= 2)
            check16("ramp_up_tick_period", 16'(launch_cyc[1] - launch_cyc[0]), 16'(P));

        // Ramp down across zero, landing exactly on C000.
        pid_val = 16'h7F00;
        start_phase("ramp_down", 16'h4000, 16'hC000, 16'h3000);
        push_ev(EV_LAUNCH, 16'h1000, 16'h4000); push_ev(EV_VALID, 16'h7F00, 16'h0);
        push_ev(EV_LAUNCH, 16'hE000, 16'h4000); push_ev(EV_VALID, 16'h7F00, 16'h0);
        push_ev(EV_LAUNCH, 16'hC000, 16'h4000); push_ev(EV_VALID, 16'h7F00, 16'h0);
        push_ev(EV_LAUNCH, 16'hC000, 16'h4000); push_ev(EV_VALID, 16'h7F00, 16'h0);
        wait_drain("ramp_down");
        bus.loop_enable_in = 1'b0;

        // Overrun: PID takes longer than one tick period.
        pid_val = 16'h0C0C;
        pid_delay = 20;
        start_phase("overrun", 16'h0000, 16'h0100, 16'h0080);
        push_ev(EV_LAUNCH, 16'h0080, 16'h0); push_ev(EV_MISS, 16'h0, 16'h0); push_ev(EV_VALID, 16'h0C0C, 16'h0);
        push_ev(EV_LAUNCH, 16'h0100, 16'h0); push_ev(EV_MISS, 16'h0, 16'h0); push_ev(EV_VALID, 16'h0C0C, 16'h0);
        wait_drain("overrun");
        bus.loop_enable_in = 1'b0;
        if (launch_cyc.size() >= 2)
            check16("overrun_next_launch_gap", 16'(launch_cyc[1] - launch_cyc[0]), 16'(2 * P));

        // Enable drops in WAIT_DONE: handshake still completes, then bumpless restart.
        pid_val = 16'h5555;
        pid_delay = 9;
        start_phase("disable", 16'h0000, 16'h0800, 16'h0800);
        push_ev(EV_LAUNCH, 16'h0800, 16'h0); push_ev(EV_VALID, 16'h5555, 16'h0);
        for (int i = 0; i < 200 && exp_q.size() > 1; i++) begin
            @(negedge sys_clk);
            #1;
        end
        repeat (2) @(negedge sys_clk);
        bus.loop_enable_in = 1'b0;
        wait_drain("disable_in_wait_done");
        pid_val = 16'h3C3C;
        start_phase("reenable", 16'h2000, 16'h2800, 16'h0100);
        push_ev(EV_LAUNCH, 16'h2100, 16'h2000); push_ev(EV_VALID, 16'h3C3C, 16'h0);
        wait_drain("reenable");
        bus.loop_enable_in = 1'b0;

`ifdef PID_DONE_TIMEOUT_EN
        pid_respond = 1'b0;
        start_phase("timeout", 16'h0000, 16'h0100, 16'h0100);
        push_ev(EV_LAUNCH, 16'h0100, 16'h0); push_ev(EV_TMO, 16'h0, 16'h0);
        wait_drain("timeout");
        bus.loop_enable_in = 1'b0;
        if (launch_cyc.size() >= 1)
            check16("timeout_cycle", 16'(tmo_cyc - launch_cyc[0]), 16'(TO + 1));
        check16("timeout_ctrl_held", bus.control_value_out, 16'h3C3C);
`endif

        // Asynchronous reset while waiting for a done that never comes.
        pid_respond = 1'b0;
        start_phase("midreset", 16'h0000, 16'h0100, 16'h0100);
        push_ev(EV_LAUNCH, 16'h0100, 16'h0);
        wait_drain("midreset_launch");
        repeat (3) @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("async_reset");
        bus.loop_enable_in = 1'b0;
        @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (40) @(negedge sys_clk);
        check16("no_pending_events", 16'(exp_q.size()), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
